idsm_conversion_sequencer: RTL and testbench

Sequences incremental-DSM conversions on the decimation filter. It issues single-cycle filter reset pulses at a programmable oversampling ratio (OSR), holds the modulator in reset while idle, and captures the filter's dumped result into a one-entry output register with a valid/ready handshake. The filter is strapped to type 1 (type_dec = 0). The block sits between the chip-level control pins and the filter's reset/Z ports.

---
 rtl/idsm_conversion_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_idsm_conversion_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idsm_conversion_sequencer.sv
// Incremental-DSM conversion sequencer: paces filter reset pulses at the
// latched OSR, gates the modulator reset, and captures filter results into a
// one-entry valid/ready output register.
module idsm_conversion_sequencer #(
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned OSR_BITS  = 8,
   parameter int unsigned CAP_LAT   = 2,
   parameter int unsigned OSR_MIN   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 continuous,
   input  logic                 abort,
   input  logic [OSR_BITS-1:0]  osr,
   input  logic [DATA_BITS-1:0] filt_z,
   output logic                 filt_reset,
   output logic                 mod_reset,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy,
   output logic                 overrun,
   output logic [7:0]           conv_count
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [OSR_BITS-1:0]  cnt_q, cnt_d;
   logic [OSR_BITS-1:0]  osr_l_q, osr_l_d;
   logic                 cont_l_q, cont_l_d;
   logic [CAP_LAT-1:0]   cap_pipe_q, cap_pipe_d;
   logic                 filt_reset_q, filt_reset_d;
   logic                 mod_reset_q, mod_reset_d;
   logic                 busy_q, busy_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 overrun_q, overrun_d;
   logic [CNT_W-1:0]     conv_count_q, conv_count_d;

   logic                 sched_c;
   logic                 cancel_c;
   logic                 capture_c;
   logic [OSR_BITS-1:0]  osr_clamped_c;
   logic [OSR_BITS-1:0]  osr_last_c;

   // OSR floor applied at latch time; last count value of a period
   assign osr_clamped_c = (osr < OSR_BITS'(OSR_MIN)) ? OSR_BITS'(OSR_MIN) : osr;
   assign osr_last_c    = osr_l_q - OSR_BITS'(1);

   // Next-state, pulse scheduling, capture pipeline and output register logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      osr_l_d      = osr_l_q;
      cont_l_d     = cont_l_q;
      filt_reset_d = 1'b0;
      mod_reset_d  = mod_reset_q;
      overrun_d    = overrun_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      conv_count_d = conv_count_q;
      sched_c      = 1'b0;
      cancel_c     = 1'b0;
      capture_c    = 1'b0;
      cap_pipe_d   = '0;

      case (state_q)
         ST_IDLE: begin
            mod_reset_d = 1'b1;
            if (start && !abort) begin
               osr_l_d      = osr_clamped_c;
               cont_l_d     = continuous;
               overrun_d    = 1'b0;
               cnt_d        = '0;
               filt_reset_d = 1'b1;
               mod_reset_d  = 1'b0;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == osr_last_c) begin
               cnt_d        = '0;
               filt_reset_d = 1'b1;
               sched_c      = 1'b1;
               if (!cont_l_q) begin
                  mod_reset_d = 1'b1;
                  state_d     = ST_DRAIN;
               end
            end else begin
               cnt_d = cnt_q + OSR_BITS'(1);
            end
         end
         ST_DRAIN: begin
            if (cap_pipe_q[CAP_LAT-1]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything in an active sequence, including a capture due now
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         filt_reset_d = 1'b0;
         mod_reset_d  = 1'b1;
         sched_c      = 1'b0;
         cancel_c     = 1'b1;
      end

      if (!cancel_c) begin
         cap_pipe_d[0] = sched_c;
         for (int i = 1; i < int'(CAP_LAT); i++) begin
            cap_pipe_d[i] = cap_pipe_q[i-1];
         end
         capture_c = cap_pipe_q[CAP_LAT-1];
      end

      if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end

      // A capture into an unconsumed, un-accepted slot is dropped and flagged
      if (capture_c) begin
         conv_count_d = conv_count_q + CNT_W'(1);
         if (data_valid_q && !data_ready) begin
            overrun_d = 1'b1;
         end else begin
            data_out_d   = filt_z;
            data_valid_d = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         osr_l_q      <= OSR_BITS'(OSR_MIN);
         cont_l_q     <= 1'b0;
         cap_pipe_q   <= '0;
         filt_reset_q <= 1'b0;
         mod_reset_q  <= 1'b1;
         busy_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         conv_count_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         osr_l_q      <= osr_l_d;
         cont_l_q     <= cont_l_d;
         cap_pipe_q   <= cap_pipe_d;
         filt_reset_q <= filt_reset_d;
         mod_reset_q  <= mod_reset_d;
         busy_q       <= busy_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
         conv_count_q <= conv_count_d;
      end
   end

   assign filt_reset = filt_reset_q;
   assign mod_reset  = mod_reset_q;
   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign overrun    = overrun_q;
   assign conv_count = conv_count_q;

endmodule

// File: tb/tb_idsm_conversion_sequencer.sv
// Directed bench for idsm_conversion_sequencer using a free-running counter as the filter stub.
module tb_idsm_conversion_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        continuous;
   logic        abort;
   logic [7:0]  osr;
   logic [15:0] filt_z;
   logic        filt_reset;
   logic        mod_reset;
   logic [15:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        overrun;
   logic [7:0]  conv_count;

   logic [15:0] cyc = 16'd0;
   logic [15:0] cyc_e0;
   logic [15:0] held;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_count;
   int          p;

   idsm_conversion_sequencer #(
      .DATA_BITS(16), .OSR_BITS(8), .CAP_LAT(2), .OSR_MIN(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .continuous (continuous),
      .abort      (abort),
      .osr        (osr),
      .filt_z     (filt_z),
      .filt_reset (filt_reset),
      .mod_reset  (mod_reset),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .overrun    (overrun),
      .conv_count (conv_count)
   );

   always #5 clk = ~clk;

   // Filter stub: Z equals the number of elapsed clock edges
   always @(posedge clk) cyc <= cyc + 16'd1;
   assign filt_z = cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise start across one edge (E0) and remember the stub value right after E0
   task automatic do_start(input logic [7:0] osr_v, input logic cont_v);
      osr        = osr_v;
      continuous = cont_v;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
      cyc_e0     = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
      osr = 8'd0; data_ready = 1'b0;
      #23;
      check_eq("rst_mod_reset",  32'(mod_reset), 32'd1);
      check_eq("rst_filt_reset", 32'(filt_reset), 32'd0);
      check_eq("rst_busy",       32'(busy), 32'd0);
      check_eq("rst_valid",      32'(data_valid), 32'd0);
      check_eq("rst_count",      32'(conv_count), 32'd0);
      reset = 1'b0;
      tick(1);

      // abort has priority over start in IDLE
      abort = 1'b1; start = 1'b1; osr = 8'd8;
      tick(1);
      check_eq("idle_abort_busy", 32'(busy), 32'd0);
      check_eq("idle_abort_fr",   32'(filt_reset), 32'd0);
      abort = 1'b0; start = 1'b0;

      // Single conversion, osr = 8; osr/continuous changes after start are ignored
      do_start(8'd8, 1'b0);
      check_eq("t1_e0_fr",   32'(filt_reset), 32'd1);
      check_eq("t1_e0_mod",  32'(mod_reset), 32'd0);
      check_eq("t1_e0_busy", 32'(busy), 32'd1);
      osr = 8'd200; continuous = 1'b1;
      for (int k = 1; k < 8; k++) begin
         tick(1);
         check_eq("t1_fr_low",  32'(filt_reset), 32'd0);
         check_eq("t1_mod_low", 32'(mod_reset), 32'd0);
      end
      tick(1);
      check_eq("t1_e8_fr",   32'(filt_reset), 32'd1);
      check_eq("t1_e8_mod",  32'(mod_reset), 32'd1);
      check_eq("t1_e8_busy", 32'(busy), 32'd1);
      tick(1);
      check_eq("t1_e9_fr",    32'(filt_reset), 32'd0);
      check_eq("t1_e9_valid", 32'(data_valid), 32'd0);
      tick(1);
      check_eq("t1_e10_valid", 32'(data_valid), 32'd1);
      check_eq("t1_e10_data",  32'(data_out), 32'(cyc_e0 + 16'd9));
      check_eq("t1_e10_count", 32'(conv_count), 32'd1);
      check_eq("t1_e10_busy",  32'(busy), 32'd0);
      check_eq("t1_e10_mod",   32'(mod_reset), 32'd1);
      exp_count = 1;
      data_ready = 1'b1;
      tick(1);
      check_eq("t1_consume", 32'(data_valid), 32'd0);

      // Continuous, osr = 16, consumer always ready: captures at E0+18+16k
      do_start(8'd16, 1'b1);
      p = 0;
      for (int k = 0; k < 5; k++) begin
         tick(18 + 16 * k - p);
         p = 18 + 16 * k;
         exp_count++;
         check_eq("t3_valid", 32'(data_valid), 32'd1);
         check_eq("t3_data",  32'(data_out), 32'(cyc_e0 + 16'(17 + 16 * k)));
         check_eq("t3_count", 32'(conv_count), 32'(exp_count));
         check_eq("t3_ovr",   32'(overrun), 32'd0);
      end
      tick(1);
      check_eq("t3_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_eq("t3_abort_busy", 32'(busy), 32'd0);
      check_eq("t3_abort_mod",  32'(mod_reset), 32'd1);

      // Continuous, osr = 3 clamped to 4, consumer stalled -> overrun
      data_ready = 1'b0;
      do_start(8'd3, 1'b1);
      tick(3);
      check_eq("t4_e3_fr", 32'(filt_reset), 32'd0);
      tick(1);
      check_eq("t4_e4_fr", 32'(filt_reset), 32'd1);
      tick(2);
      exp_count++;
      held = cyc_e0 + 16'd5;
      check_eq("t4_cap1_valid", 32'(data_valid), 32'd1);
      check_eq("t4_cap1_data",  32'(data_out), 32'(held));
      check_eq("t4_cap1_ovr",   32'(overrun), 32'd0);
      tick(4);
      exp_count++;
      check_eq("t4_cap2_data",  32'(data_out), 32'(held));
      check_eq("t4_cap2_ovr",   32'(overrun), 32'd1);
      check_eq("t4_cap2_count", 32'(conv_count), 32'(exp_count));
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_eq("t4_abort_busy",  32'(busy), 32'd0);
      check_eq("t4_abort_valid", 32'(data_valid), 32'd1);
      check_eq("t4_abort_data",  32'(data_out), 32'(held));
      check_eq("t4_abort_ovr",   32'(overrun), 32'd1);

      // New start clears overrun; capture coinciding with accept reloads
      do_start(8'd8, 1'b0);
      check_eq("t4b_ovr_clr", 32'(overrun), 32'd0);
      check_eq("t4b_held",    32'(data_out), 32'(held));
      tick(9);
      data_ready = 1'b1;
      tick(1);
      exp_count++;
      check_eq("t4b_valid", 32'(data_valid), 32'd1);
      check_eq("t4b_data",  32'(data_out), 32'(cyc_e0 + 16'd9));
      check_eq("t4b_ovr",   32'(overrun), 32'd0);
      check_eq("t4b_count", 32'(conv_count), 32'(exp_count));
      tick(1);
      check_eq("t4b_consume", 32'(data_valid), 32'd0);

      // Abort early in RUN: no second pulse, no capture
      do_start(8'd8, 1'b0);
      tick(5);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_eq("t5_busy", 32'(busy), 32'd0);
      check_eq("t5_mod",  32'(mod_reset), 32'd1);
      for (int k = 0; k < 8; k++) begin
         check_eq("t5_fr_low", 32'(filt_reset), 32'd0);
         check_eq("t5_valid",  32'(data_valid), 32'd0);
         tick(1);
      end
      check_eq("t5_count", 32'(conv_count), 32'(exp_count));

      // Abort with a capture pending cancels the capture
      do_start(8'd8, 1'b0);
      tick(8);
      check_eq("t5b_e8_fr", 32'(filt_reset), 32'd1);
      tick(1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_eq("t5b_busy",  32'(busy), 32'd0);
      check_eq("t5b_valid", 32'(data_valid), 32'd0);
      tick(3);
      check_eq("t5b_valid_late", 32'(data_valid), 32'd0);
      check_eq("t5b_count",      32'(conv_count), 32'(exp_count));

      // Async reset mid-RUN, between edges
      data_ready = 1'b0;
      do_start(8'd8, 1'b1);
      tick(8);
      tick(2);
      check_eq("t6_pre_valid", 32'(data_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_fr",    32'(filt_reset), 32'd0);
      check_eq("t6_mod",   32'(mod_reset), 32'd1);
      check_eq("t6_data",  32'(data_out), 32'd0);
      check_eq("t6_valid", 32'(data_valid), 32'd0);
      check_eq("t6_busy",  32'(busy), 32'd0);
      check_eq("t6_count", 32'(conv_count), 32'd0);
      #1;
      reset = 1'b0;
      tick(1);
      check_eq("t6_idle_busy", 32'(busy), 32'd0);
      do_start(8'd8, 1'b0);
      tick(9);
      check_eq("t6_e9_valid", 32'(data_valid), 32'd0);
      tick(1);
      check_eq("t6_valid_after", 32'(data_valid), 32'd1);
      check_eq("t6_data_after",  32'(data_out), 32'(cyc_e0 + 16'd9));
      check_eq("t6_count_after", 32'(conv_count), 32'd1);
      check_eq("t6_busy_after",  32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
